// File: rtl/life_board_ctrl.sv
// Seed loader and run sequencer for the 4x4 life array: writes a 16-cell
// pattern one cell per clock, runs N generations (or until stop), snapshots the board.
module life_board_ctrl #(
   parameter int GEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      pat_data,
   input  logic             pat_valid,
   output logic             pat_ready,
   input  logic [GEN_W-1:0] gens,
   input  logic             stop,
   output logic [1:0]       row,
   output logic [1:0]       col,
   output logic             val,
   output logic             write_enb,
   output logic             run,
   input  logic [15:0]      alive,
   output logic             busy,
   output logic             done,
   output logic [15:0]      snap
);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [15:0]      pat_q, pat_d;
   logic [GEN_W-1:0] gens_q, gens_d;
   logic [GEN_W-1:0] cnt_q, cnt_d;
   logic             pat_ready_q, pat_ready_d;
   logic [1:0]       row_q, row_d, col_q, col_d;
   logic             val_q, val_d;
   logic             we_q, we_d;
   logic             run_q, run_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [15:0]      snap_q, snap_d;
   logic             last_gen;

   // cnt_q counts completed run cycles; compare is only meaningful for a nonzero count
   assign last_gen = (gens_q != '0) && (cnt_q == gens_q - GEN_W'(1));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pat_d       = pat_q;
      gens_d      = gens_q;
      cnt_d       = cnt_q;
      pat_ready_d = 1'b0;
      row_d       = 2'd0;
      col_d       = 2'd0;
      val_d       = 1'b0;
      we_d        = 1'b0;
      run_d       = 1'b0;
      done_d      = 1'b0;
      snap_d      = snap_q;
      case (state_q)
         IDLE: begin
            pat_ready_d = 1'b1;
            if (pat_valid && pat_ready_q) begin
               state_d     = LOAD;
               pat_d       = pat_data;
               gens_d      = gens;
               idx_d       = 4'd0;
               cnt_d       = '0;
               pat_ready_d = 1'b0;
               we_d        = 1'b1;
               val_d       = pat_data[0];
            end
         end
         LOAD: begin
            if (idx_q == 4'd15) begin
               state_d = SETTLE;
            end else begin
               idx_d          = idx_q + 4'd1;
               we_d           = 1'b1;
               {col_d, row_d} = idx_d;
               val_d          = pat_q[idx_d];
            end
         end
         SETTLE: begin
            state_d = RUN;
            run_d   = 1'b1;
            cnt_d   = '0;
         end
         RUN: begin
            // a stop that lands on the final counted cycle takes the same exit
            if (last_gen || stop) begin
               state_d = DONE;
            end else begin
               run_d = 1'b1;
               if (gens_q != '0) cnt_d = cnt_q + GEN_W'(1);
            end
         end
         DONE: begin
            state_d     = IDLE;
            pat_ready_d = 1'b1;
            snap_d      = alive;
            done_d      = 1'b1;
            idx_d       = 4'd0;
            cnt_d       = '0;
         end
         default: begin
            state_d     = IDLE;
            pat_ready_d = 1'b1;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         pat_q       <= 16'd0;
         gens_q      <= '0;
         cnt_q       <= '0;
         pat_ready_q <= 1'b1;
         row_q       <= 2'd0;
         col_q       <= 2'd0;
         val_q       <= 1'b0;
         we_q        <= 1'b0;
         run_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         snap_q      <= 16'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pat_q       <= pat_d;
         gens_q      <= gens_d;
         cnt_q       <= cnt_d;
         pat_ready_q <= pat_ready_d;
         row_q       <= row_d;
         col_q       <= col_d;
         val_q       <= val_d;
         we_q        <= we_d;
         run_q       <= run_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         snap_q      <= snap_d;
      end
   end

   assign pat_ready = pat_ready_q;
   assign row       = row_q;
   assign col       = col_q;
   assign val       = val_q;
   assign write_enb = we_q;
   assign run       = run_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign snap      = snap_q;

endmodule

// File: doc/life_board_ctrl.md
Name: life_board_ctrl

Overview:
- Initiator for the 4x4 life array's cell-write and run interface.
- Accepts a 16-cell seed pattern over a valid/ready handshake, then writes it into the array one cell per clock.
- Runs the array for a programmed number of generations, or free-runs until told to stop.
- Captures the final board into a snapshot register and pulses done; sits between host/test logic and the array.

Parameters:
GEN_W, 8, width of the generation count input and internal generation counter.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
pat_data  input  16  seed pattern; bit i = cell at col=i[3:2], row=i[1:0]
pat_valid  input  1  pattern offer
pat_ready  output  1  controller can accept a pattern
gens  input  GEN_W  generations to run; sampled with pattern; 0 = free-run until stop
stop  input  1  terminate a run
row  output  2  array cell row for write
col  output  2  array cell column for write
val  output  1  array cell write value
write_enb  output  1  array cell write strobe
run  output  1  array enable; array advances one generation per clk while high
alive  input  16  array state, same bit mapping as pat_data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when snap is updated
snap  output  16  alive captured at end of run

Behaviour:
- Reset (reset==0 at a clk edge), from any state, including mid-LOAD or mid-RUN:
  - state=IDLE; pat_ready=1; snap=0; all other outputs 0.
  - Internal index, generation counter and latched pattern are cleared.
- States: IDLE, LOAD, SETTLE, RUN, DONE. All outputs are registered.
- IDLE:
  - pat_ready=1.
  - On pat_valid&pat_ready at edge T: latch pat_data and gens, idx=0, go to LOAD.
  - pat_ready=0 from T+1 until re-entering IDLE; pat_valid is ignored while not ready.
- LOAD: cycles T+1..T+16.
  - write_enb=1; col=idx[3:2]; row=idx[1:0]; val=pattern[idx].
  - idx increments each cycle; after idx=15 go to SETTLE.
  - Every cell is written, including zeros.
- SETTLE: cycle T+17. All strobes low; lets the final write land.
- RUN, gens=G>0:
  - run=1 for exactly G cycles (T+18..T+17+G), then go to DONE.
  - The generation counter wraps from G-1 only to exit; it never overflows.
- RUN, G=0:
  - run stays 1 until stop is sampled high.
  - run=0 the next cycle, then go to DONE.
- stop:
  - With G>0, stop during RUN ends the run early, same timing as the G=0 case.
  - stop on the same cycle as the final counted generation ends the run normally: exactly one done.
  - stop is ignored in IDLE, LOAD, SETTLE and DONE.
- DONE: one cycle.
  - snap<=alive (state after the last run cycle); done=1 in the cycle after capture.
  - Then return to IDLE with pat_ready=1.
- write_enb and run are never high together.
- row, col and val are 0 outside LOAD.

Test Plan:
- Reset: hold reset=0 for 3 clks with pat_valid=1 -> pat_ready=1, busy=0, write_enb=0, run=0, done=0, snap=0x0000; no pattern accepted.
- Load sequence: offer 0xA5C3, gens=1, accepted at T -> T+1..T+16 show (col,row,val) for idx 0..15 with val=bit idx of 0xA5C3; write_enb high exactly 16 cycles; run high exactly 1 cycle at T+18.
- Blinker: 0x0070, gens=1 -> snap=0x0222 with single done pulse. Same seed, gens=2 -> snap=0x0070. Block 0x0660, gens=3 -> snap=0x0660.
- Free-run: 0x0070, gens=0, stop pulsed after 5 run cycles -> run high exactly 5 cycles; snap=0x0222; done once.
- Stop coincident with the 4th cycle of gens=4 -> run high 4 cycles; exactly one done; then IDLE.
- Reset mid-LOAD at idx=7 -> next cycle IDLE, write_enb=0, snap=0. Then pat_valid held through a full run -> second pattern accepted only when IDLE reasserts pat_ready.
